// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2_ADV DRP reconfiguration controller.
// Holds the controller state encoding, DRP bus widths, well-known PLL register
// addresses and the masked-merge helper used for read-modify-write.
package pll_drp_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  typedef enum logic [3:0] {
    IDLE,
    HOLD,
    READ,
    WAIT_RD,
    WRITE,
    WAIT_WR,
    NEXT,
    RELEASE,
    WAIT_LOCK,
    ERR
  } state_t;

  // PLLE2_ADV DRP register map (subset used by reconfiguration sequences)
  localparam logic [DRP_AW-1:0] ADDR_CLKOUT0_1  = 7'h08;
  localparam logic [DRP_AW-1:0] ADDR_CLKOUT0_2  = 7'h09;
  localparam logic [DRP_AW-1:0] ADDR_CLKFBOUT_1 = 7'h14;
  localparam logic [DRP_AW-1:0] ADDR_CLKFBOUT_2 = 7'h15;
  localparam logic [DRP_AW-1:0] ADDR_DIVCLK     = 7'h16;
  localparam logic [DRP_AW-1:0] ADDR_LOCK1      = 7'h18;
  localparam logic [DRP_AW-1:0] ADDR_LOCK2      = 7'h19;
  localparam logic [DRP_AW-1:0] ADDR_LOCK3      = 7'h1A;
  localparam logic [DRP_AW-1:0] ADDR_FILT1      = 7'h4E;
  localparam logic [DRP_AW-1:0] ADDR_FILT2      = 7'h4F;

  // mask bit = 1 keeps the bit read from the PLL, 0 takes the new value
  function automatic logic [DRP_DW-1:0] merge_bits(input logic [DRP_DW-1:0] old_val,
                                                   input logic [DRP_DW-1:0] mask,
                                                   input logic [DRP_DW-1:0] new_val);
    return (old_val & mask) | (new_val & ~mask);
  endfunction

endpackage

// File: rtl/pll_drp_ctrl_sync_2ff.sv
// Two-flop synchronizer for a slow asynchronous level (PLL LOCKED).
// Latency: 2 clock cycles. No backpressure.
// Ports: clock, reset (async active-low), d (async input), q (synchronized).
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_drp_ctrl.sv
// DRP initiator: masked read-modify-write of PLLE2_ADV registers with the PLL held in reset, then relock.
// Latency: accept -> RST_HOLD+1 hold cycles -> read -> write per entry; done 3 cycles after LOCKED rises.
// Backpressure: req_ready only in IDLE/NEXT; the host may stall indefinitely between entries.
// Ports: clock (also PLL DCLK), reset (async active-low), req_* host entry stream,
//        busy/done/error status, drp_* DRP initiator bus, pll_rst/pll_locked PLL control.
module pll_drp_ctrl
  import pll_drp_pkg::*;
#(
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DRP_AW-1:0] req_addr,
  input  logic [DRP_DW-1:0] req_mask,
  input  logic [DRP_DW-1:0] req_data,
  input  logic              req_last,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DRP_AW-1:0] drp_daddr,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [DRP_DW-1:0] drp_di,
  input  logic [DRP_DW-1:0] drp_do,
  input  logic              drp_drdy,
  output logic              pll_rst,
  input  logic              pll_locked
);

  localparam int HW = $clog2(RST_HOLD) + 1;
  localparam int TW = $clog2(DRDY_TIMEOUT) + 1;
  localparam int LW = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);
  localparam logic [TW-1:0] TO_LAST   = TW'(DRDY_TIMEOUT - 1);
  localparam logic [LW-1:0] LK_LAST   = LW'(LOCK_TIMEOUT - 1);

  state_t            state;
  logic [HW-1:0]     hold_cnt;
  logic [TW-1:0]     to_cnt;
  logic [LW-1:0]     lock_cnt;
  logic [DRP_DW-1:0] lat_mask;
  logic [DRP_DW-1:0] lat_data;
  logic              lat_last;
  logic              locked_s;

  wire accept = req_valid && req_ready;

  sync_2ff u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // drp_daddr doubles as the latched entry address; it only changes on accept,
  // so it is stable for the whole read-modify-write of that entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_daddr <= '0;
      drp_di    <= '0;
      pll_rst   <= 1'b0;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      lock_cnt  <= '0;
      lat_mask  <= '0;
      lat_data  <= '0;
      lat_last  <= 1'b0;
    end else begin
      done    <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            drp_daddr <= req_addr;
            lat_mask  <= req_mask;
            lat_data  <= req_data;
            lat_last  <= req_last;
            error     <= 1'b0;
            busy      <= 1'b1;
            pll_rst   <= 1'b1;
            hold_cnt  <= HOLD_INIT;
            req_ready <= 1'b0;
            state     <= HOLD;
          end else begin
            req_ready <= 1'b1;
          end
        end

        HOLD: begin
          if (hold_cnt == '0) begin
            drp_den <= 1'b1;
            state   <= READ;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        READ: begin
          to_cnt <= '0;
          state  <= WAIT_RD;
        end

        WAIT_RD: begin
          if (drp_drdy) begin
            drp_di  <= merge_bits(drp_do, lat_mask, lat_data);
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            state   <= WRITE;
          end else if (to_cnt >= TO_LAST) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            pll_rst <= 1'b0;
            state   <= ERR;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        WRITE: begin
          to_cnt <= '0;
          state  <= WAIT_WR;
        end

        WAIT_WR: begin
          if (drp_drdy) begin
            if (lat_last) begin
              pll_rst <= 1'b0;
              state   <= RELEASE;
            end else begin
              req_ready <= 1'b1;
              state     <= NEXT;
            end
          end else if (to_cnt >= TO_LAST) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            pll_rst <= 1'b0;
            state   <= ERR;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        // PLL stays in reset while the host prepares the next entry; no hold needed
        NEXT: begin
          if (accept) begin
            drp_daddr <= req_addr;
            lat_mask  <= req_mask;
            lat_data  <= req_data;
            lat_last  <= req_last;
            req_ready <= 1'b0;
            drp_den   <= 1'b1;
            state     <= READ;
          end
        end

        RELEASE: begin
          lock_cnt <= '0;
          state    <= WAIT_LOCK;
        end

        WAIT_LOCK: begin
          if (locked_s) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else if (lock_cnt >= LK_LAST) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            pll_rst <= 1'b0;
            state   <= ERR;
          end else if (lock_cnt != '1) begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        // outputs were already driven on entry; one cycle here, then back to IDLE
        ERR: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Self-checking bench for pll_drp_ctrl: host driver, DRP responder backed by a
// register array standing in for the PLL, and a LOCKED generator.
// Expected register contents come from a separate reference array per entry.
module tb_pll_drp_ctrl;
  import pll_drp_pkg::*;

  // shortened lock timeout keeps the timeout scenario brief
  localparam int LT = 2000;

  typedef struct packed {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
    logic [31:0] cyc;
  } acc_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_last;
  logic [6:0]  req_addr;
  logic [15:0] req_mask, req_data;
  logic        busy, done, error;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [15:0] drp_di, drp_do;
  logic        pll_rst, pll_locked;

  always #5 clock = ~clock;

  pll_drp_ctrl #(.RST_HOLD(4), .DRDY_TIMEOUT(64), .LOCK_TIMEOUT(LT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_mask(req_mask), .req_data(req_data), .req_last(req_last),
    .busy(busy), .done(done), .error(error),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // knobs written by the main sequence only
  int max_lat = 1;
  bit drop_rd = 0, drop_wr = 0;
  int lock_mode = 0;
  int spur_cnt = 0;

  // written by the responder/monitor only
  logic [15:0] mem [128];
  acc_t acc_log[$];
  int pend = 0;
  int overlap_viol = 0, rst_viol = 0, ready_viol = 0;
  int t_rst_rise = 0, t_rst_fall = 0;
  // written by the lock generator only
  int t_lock_rise = 0;

  // main-sequence state
  logic [15:0] ref_mem [128];
  logic [6:0]  seq_a[$];
  logic [15:0] seq_m[$], seq_d[$];
  int last_base = 0;

  function automatic logic [15:0] init_val(input int i);
    if (i == 8) return 16'h1041;
    return 16'(i * 40503) ^ 16'h3c5a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // DRP responder + protocol monitor
  initial begin
    int spur_seen;
    bit pend_we, outst, prev_rst;
    logic [6:0] pend_addr;
    acc_t e;
    spur_seen = 0; pend_we = 0; pend_addr = '0; prev_rst = 0;
    for (int i = 0; i < 128; i++) mem[i] = init_val(i);
    drp_drdy = 0; drp_do = '0;
    forever begin
      @(negedge clock);
      outst = (pend != 0);
      if (req_ready && (outst || drp_den)) ready_viol++;
      drp_drdy = 0;
      drp_do = 16'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drp_drdy = 1;
          if (!pend_we) drp_do = mem[pend_addr];
        end
      end
      if (drp_den) begin
        if (outst) overlap_viol++;
        if (!pll_rst) rst_viol++;
        e.addr = drp_daddr; e.we = drp_dwe; e.di = drp_di; e.cyc = 32'(cyc);
        acc_log.push_back(e);
        if (drp_dwe) mem[drp_daddr] = drp_di;
        if ((drp_dwe && !drop_wr) || (!drp_dwe && !drop_rd)) begin
          pend = $urandom_range(1, max_lat);
          pend_we = drp_dwe;
          pend_addr = drp_daddr;
        end
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        drp_drdy = 1;
      end
      if (pll_rst && !prev_rst) t_rst_rise = cyc;
      if (!pll_rst && prev_rst) t_rst_fall = cyc;
      prev_rst = pll_rst;
    end
  end

  // PLL LOCKED model: 0 = locks 10 cycles after release, 1 = never locks,
  // 2 = single one-cycle LOCKED blip 100 cycles after release
  initial begin
    int cnt;
    bit blipped;
    cnt = 0; blipped = 0;
    pll_locked = 0;
    forever begin
      @(negedge clock);
      if (pll_rst) begin
        pll_locked = 0; cnt = 0; blipped = 0;
      end else begin
        if (cnt < 1000000) cnt++;
        case (lock_mode)
          0: if (cnt >= 10 && !pll_locked) begin pll_locked = 1; t_lock_rise = cyc; end
          1: pll_locked = 0;
          default: begin
            if (cnt == 100 && !blipped) begin
              pll_locked = 1; blipped = 1; t_lock_rise = cyc;
            end else pll_locked = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                      input logic l, output bit ok);
    ok = 0;
    req_addr = a; req_mask = m; req_data = d; req_last = l; req_valid = 1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (req_ready) ok = 1;
      @(negedge clock);
    end
    req_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_end(input int budget, output bit gd, output bit ge, output int t);
    gd = 0; ge = 0; t = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin gd = 1; t = cyc; break; end
      if (error) begin ge = 1; t = cyc; break; end
      @(negedge clock);
    end
    if (!gd && !ge) chk("end_timeout", 0, 1);
  endtask

  task automatic seq_push(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    seq_a.push_back(a); seq_m.push_back(m); seq_d.push_back(d);
  endtask

  task automatic seq_clear();
    seq_a.delete(); seq_m.delete(); seq_d.delete();
  endtask

  // Each entry must appear as a read then a write of the merged value; the
  // PLL register array must end up equal to the reference array.
  task automatic check_log(input int base);
    int n;
    logic [15:0] exp_di;
    n = seq_a.size();
    chk("num_accesses", acc_log.size() - base, 2 * n);
    for (int i = 0; i < n; i++) begin
      exp_di = (ref_mem[seq_a[i]] & seq_m[i]) | (seq_d[i] & ~seq_m[i]);
      ref_mem[seq_a[i]] = exp_di;
      if (base + 2 * i + 1 < acc_log.size()) begin
        chk("rd_addr", acc_log[base + 2 * i].addr, seq_a[i]);
        chk("rd_we", acc_log[base + 2 * i].we, 0);
        chk("wr_addr", acc_log[base + 2 * i + 1].addr, seq_a[i]);
        chk("wr_we", acc_log[base + 2 * i + 1].we, 1);
        chk("wr_di", acc_log[base + 2 * i + 1].di, exp_di);
      end
    end
    for (int i = 0; i < n; i++) chk("pll_reg", mem[seq_a[i]], ref_mem[seq_a[i]]);
  endtask

  task automatic run_seq(input int gap_max);
    int base, t;
    bit ok, gd, ge;
    base = acc_log.size();
    for (int i = 0; i < seq_a.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, gap_max)) @(negedge clock);
      send(seq_a[i], seq_m[i], seq_d[i], (i == seq_a.size() - 1), ok);
      if (i == 0) chk("err_clear_on_accept", error, 0);
    end
    wait_end(LT + 500, gd, ge, t);
    chk("seq_done", gd, 1);
    chk("seq_err", ge, 0);
    chk("seq_busy", busy, 0);
    if (gd) chk("lock_to_done", t - t_lock_rise, 3);
    check_log(base);
    last_base = base;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_den", drp_den, 0);
    chk("rst_dwe", drp_dwe, 0);
    chk("rst_daddr", drp_daddr, 0);
    chk("rst_di", drp_di, 0);
    chk("rst_pll_rst", pll_rst, 0);
  endtask

  logic [6:0] atab [10];

  initial begin
    int base, t, d;
    bit ok, gd, ge, flag;
    logic [5:0] pat;
    logic [6:0] a;

    atab = '{ADDR_CLKOUT0_1, ADDR_CLKOUT0_2, ADDR_CLKFBOUT_1, ADDR_CLKFBOUT_2, ADDR_DIVCLK,
             ADDR_LOCK1, ADDR_LOCK2, ADDR_LOCK3, ADDR_FILT1, ADDR_FILT2};
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    req_valid = 0; req_addr = '0; req_mask = '0; req_data = '0; req_last = 0;

    reset = 1;
    #1 reset = 0;
    #2 chk_reset_vals();
    repeat (3) @(negedge clock);
    reset = 1;
    repeat (3) @(negedge clock);
    chk("idle_ready", req_ready, 1);

    // single-register sequence with known values
    max_lat = 1;
    seq_clear(); seq_push(7'h08, 16'hF000, 16'h0555);
    run_seq(0);
    if (acc_log.size() >= last_base + 2) begin
      chk("t1_rd_addr", acc_log[last_base].addr, 7'h08);
      chk("t1_wr_di", acc_log[last_base + 1].di, 16'h1555);
      chk("t1_rst_hold", (int'(acc_log[last_base].cyc) - t_rst_rise) >= 4, 1);
    end
    chk("t1_error", error, 0);

    // three entries with a 5-cycle host gap after the first
    seq_clear();
    seq_push(ADDR_CLKOUT0_1, 16'($urandom), 16'($urandom));
    seq_push(ADDR_CLKFBOUT_1, 16'($urandom), 16'($urandom));
    seq_push(ADDR_DIVCLK, 16'($urandom), 16'($urandom));
    base = acc_log.size();
    send(seq_a[0], seq_m[0], seq_d[0], 0, ok);
    for (int i = 0; i < 300 && !req_ready; i++) @(negedge clock);
    chk("t2_next_ready", req_ready, 1);
    flag = 1;
    for (int i = 0; i < 5; i++) begin
      if (!(pll_rst && req_ready && busy)) flag = 0;
      @(negedge clock);
    end
    chk("t2_gap_hold", flag, 1);
    send(seq_a[1], seq_m[1], seq_d[1], 0, ok);
    send(seq_a[2], seq_m[2], seq_d[2], 1, ok);
    wait_end(LT + 500, gd, ge, t);
    chk("t2_done", gd, 1);
    pat = '0;
    for (int i = 0; i < 6; i++)
      if (base + i < acc_log.size()) pat[i] = acc_log[base + i].we;
    chk("t2_rw_pattern", pat, 6'b101010);
    check_log(base);

    // read never acknowledged
    drop_rd = 1;
    seq_clear(); seq_push(ADDR_FILT1, 16'h00FF, 16'hA5A5);
    base = acc_log.size();
    send(seq_a[0], seq_m[0], seq_d[0], 1, ok);
    wait_end(400, gd, ge, t);
    chk("t3_error", ge, 1);
    chk("t3_no_done", gd, 0);
    if (acc_log.size() > base) begin
      d = t - int'(acc_log[base].cyc);
      chk("t3_timeout_window", (d >= 64 && d <= 66), 1);
    end
    chk("t3_pll_rst", pll_rst, 0);
    chk("t3_busy", busy, 0);
    chk("t3_no_write", acc_log.size() - base, 1);
    repeat (10) @(negedge clock);
    chk("t3_sticky", error, 1);
    drop_rd = 0;
    run_seq(0);

    // lock never arrives, then a brief LOCKED blip
    lock_mode = 1;
    seq_clear(); seq_push(ADDR_LOCK1, 16'($urandom), 16'($urandom));
    base = acc_log.size();
    send(seq_a[0], seq_m[0], seq_d[0], 1, ok);
    wait_end(LT + 500, gd, ge, t);
    chk("t4_error", ge, 1);
    chk("t4_no_done", gd, 0);
    d = t - t_rst_fall;
    chk("t4_lock_window", (d >= LT && d <= LT + 2), 1);
    chk("t4_pll_rst", pll_rst, 0);
    check_log(base);
    lock_mode = 2;
    seq_clear(); seq_push(ADDR_LOCK2, 16'($urandom), 16'($urandom));
    run_seq(0);
    lock_mode = 0;

    // asynchronous reset while the write is outstanding
    drop_wr = 1;
    seq_clear(); seq_push(ADDR_CLKFBOUT_2, 16'h0F0F, 16'h1234);
    base = acc_log.size();
    send(seq_a[0], seq_m[0], seq_d[0], 1, ok);
    for (int i = 0; i < 100 && acc_log.size() < base + 2; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    chk("t5_busy_before", busy, 1);
    chk("t5_rst_before", pll_rst, 1);
    #2 reset = 0;
    #1 chk_reset_vals();
    check_log(base);
    @(negedge clock);
    reset = 1;
    drop_wr = 0;
    spur_cnt++;
    base = acc_log.size();
    repeat (6) @(negedge clock);
    chk("t5_spur_no_den", acc_log.size() - base, 0);
    chk("t5_spur_busy", busy, 0);
    chk("t5_spur_ready", req_ready, 1);
    chk("t5_spur_error", error, 0);

    // host stalls 1000 cycles between entries
    seq_clear();
    seq_push(ADDR_CLKOUT0_2, 16'($urandom), 16'($urandom));
    seq_push(ADDR_FILT2, 16'($urandom), 16'($urandom));
    base = acc_log.size();
    send(seq_a[0], seq_m[0], seq_d[0], 0, ok);
    for (int i = 0; i < 300 && !req_ready; i++) @(negedge clock);
    flag = 1;
    for (int i = 0; i < 1000; i++) begin
      if (!pll_rst || error) flag = 0;
      @(negedge clock);
    end
    chk("t6_stall_rst_held", flag, 1);
    chk("t6_stall_no_traffic", acc_log.size() - base, 2);
    chk("t6_stall_busy", busy, 1);
    chk("t6_stall_ready", req_ready, 1);
    send(seq_a[1], seq_m[1], seq_d[1], 1, ok);
    wait_end(LT + 500, gd, ge, t);
    chk("t6_done", gd, 1);
    check_log(base);

    // randomized sequences
    for (int k = 0; k < 8; k++) begin
      max_lat = $urandom_range(1, 4);
      seq_clear();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
        if ($urandom_range(0, 1) == 1) a = atab[$urandom_range(0, 9)];
        else a = 7'($urandom);
        seq_push(a, 16'($urandom), 16'($urandom));
      end
      run_seq(8);
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    chk("den_while_outstanding", overlap_viol, 0);
    chk("den_without_pll_rst", rst_viol, 0);
    chk("ready_while_accessing", ready_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_drp_ctrl.md
Name: pll_drp_ctrl

Overview:
- DRP initiator for the 7-series PLLE2_ADV dynamic reconfiguration port. The PLL wrapper currently ties that port off.
- Accepts a stream of masked register-write entries from a host (CSR block or boot FSM). Performs read-modify-write over DRP while holding the PLL in reset, releases reset, then waits for lock.
- Runs on a free-running input clock that also drives the PLL's DCLK. Never runs on the PLL output clock.

Parameters:
- RST_HOLD, 4: minimum cycles pll_rst stays high before the first DRP access.
- DRDY_TIMEOUT, 64: cycles to wait for drp_drdy before aborting with error.
- LOCK_TIMEOUT, 65535: cycles to wait for pll_locked after reset release before error.

Ports:
- clock  in  1  controller clock; also connected to PLL DCLK.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  host entry valid.
- req_ready  out  1  entry accepted when req_valid and req_ready are both high.
- req_addr  in  7  DRP register address.
- req_mask  in  16  bit=1 keeps the existing PLL bit; bit=0 takes req_data.
- req_data  in  16  new bit values.
- req_last  in  1  marks the final entry of a reconfiguration sequence.
- busy  out  1  high from first accept until done or error.
- done  out  1  one-cycle pulse on successful lock.
- error  out  1  sticky; cleared by the next accepted first entry.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, one-cycle pulse.
- drp_dwe  out  1  DRP write enable, pulsed with drp_den for writes.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data, valid with drp_drdy.
- drp_drdy  in  1  DRP access complete.
- pll_rst  out  1  to PLL RST.
- pll_locked  in  1  from PLL LOCKED; asynchronous, passed through a 2-flop synchronizer inside.

Behaviour:
- Reset values: req_ready=0, busy=0, done=0, error=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, pll_rst=0 (PLL free-runs by default). FSM resets to IDLE.
- Reset asserted mid-operation aborts immediately to these values. The PLL is released from reset and relocks with whatever was already written.
- IDLE: req_ready=1. On accept, latch addr/mask/data/last, clear error, set busy and pll_rst, load the hold counter with RST_HOLD, go to HOLD.
- HOLD: count down to 0, then go to READ.
- READ: one cycle with drp_den=1, drp_dwe=0, drp_daddr=latched addr. Go to WAIT_RD with the timeout counter cleared.
- WAIT_RD: on drp_drdy, compute di = (drp_do & mask) | (data & ~mask), registered, then go to WRITE. If no drdy by DRDY_TIMEOUT cycles, go to ERR.
- WRITE: one cycle with drp_den=1, drp_dwe=1, drp_di=di. Go to WAIT_WR.
- WAIT_WR: on drp_drdy, go to RELEASE if latched last=1, else NEXT. Timeout behaves as in WAIT_RD.
- NEXT: req_ready=1 and pll_rst stays high. Wait indefinitely for the next entry. On accept, latch the entry and go directly to READ (no hold).
- RELEASE: pll_rst=0, clear the lock counter, go to WAIT_LOCK.
- WAIT_LOCK: synchronized locked=1 triggers a done pulse and return to IDLE with busy=0. Reaching LOCK_TIMEOUT instead goes to ERR.
- ERR: pll_rst=0, error=1, busy=0, then IDLE.
- req_ready is 0 in every state except IDLE and NEXT.
- drp_den never asserts while a previous access is outstanding.
- A drdy arriving outside WAIT_RD/WAIT_WR is ignored.
- Counters saturate and do not wrap. Widths are clog2 of the respective parameter plus 1.
- A single entry with req_last=1 in IDLE is a valid one-register sequence.
- Latency for a single entry with drdy returned after 1 cycle each: accept -> RST_HOLD -> read -> write -> release. done follows lock by 3 cycles (synchronizer plus state register).

Decomposition:
- Shared package pll_drp_pkg:
  - FSM state enum (IDLE, HOLD, READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE, WAIT_LOCK, ERR).
  - DRP address constants: CLKOUT0 reg1/reg2 = 0x08/0x09, CLKFBOUT reg1/reg2 = 0x14/0x15, DIVCLK = 0x16, LOCK1-3 = 0x18-0x1A, FILT1-2 = 0x4E/0x4F.
  - DRP data and address width constants.
- One sub-module: sync_2ff, used for pll_locked.

Test Plan:
- Single entry addr=0x08, mask=0xF000, data=0x0555. Responder returns do=0x1041 one cycle after den. -> Read at 0x08, then write di=0x1555 with dwe=1. pll_rst high >= 4 cycles before the first den. Locked raised 10 cycles after release -> done pulse, busy=0, error=0.
- Three-entry sequence (0x08, 0x14, 0x16, last on the third) with a 5-cycle gap before the second entry. -> pll_rst stays high throughout the gap, req_ready=1 only in the gap and in IDLE. Exactly 6 den pulses in read/write alternation.
- Responder never asserts drdy on the read. -> After 64 cycles: error=1, pll_rst=0, busy=0, no write issued. Next accepted entry clears error.
- pll_locked held low after release. -> error=1 at 65535 cycles and no done pulse. Repeat with locked toggling mid-count -> done on the first synchronized high.
- Assert reset during WAIT_WR. -> All outputs at reset values immediately (async) and the FSM is in IDLE after deassertion. Spurious drdy afterwards is ignored.
- Accept the first entry, then deassert req_valid for 1000 cycles in NEXT. -> No DRP traffic, pll_rst stays 1, no timeout error.
